// File: rtl/rmt_pkg.sv
// Shared RMT pipeline definitions: default queue-field placement and a lowest-set-bit helper
// used by the parser/deparser and the queue dispatcher.
package rmt_pkg;

  localparam int unsigned MAX_QUEUES    = 16;
  localparam int unsigned C_NUM_QUEUES  = 4;
  localparam int unsigned QUEUE_BIT_OFF = 141;

  // Isolates the lowest set bit (two's-complement trick); zero in gives zero out.
  function automatic logic [MAX_QUEUES-1:0] lowest_set_bit(input logic [MAX_QUEUES-1:0] v);
    return v & (~v + 16'd1);
  endfunction

endpackage

// File: rtl/phv_queue_dispatcher.sv
// Final-stage PHV fan-out: one-slot buffer delivering each PHV to every queue in its destination
// bitmap, tracking per-queue completion; empty-destination PHVs are dropped and counted.
module phv_queue_dispatcher #(
  parameter int unsigned PHV_LEN       = 1152,
  parameter int unsigned C_NUM_QUEUES  = rmt_pkg::C_NUM_QUEUES,
  parameter int unsigned QUEUE_BIT_OFF = rmt_pkg::QUEUE_BIT_OFF,
  parameter bit          MCAST_EN      = 1'b1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                            axis_clk,
  input  logic                            aresetn,
  input  logic [PHV_LEN-1:0]              phv_in,
  input  logic                            phv_in_valid,
  output logic                            phv_in_ready,
  output logic [C_NUM_QUEUES*PHV_LEN-1:0] phv_out,
  output logic [C_NUM_QUEUES-1:0]         phv_out_valid,
  input  logic [C_NUM_QUEUES-1:0]         phv_out_ready,
  output logic [CNT_W-1:0]                drop_cnt,
  output logic [CNT_W-1:0]                fwd_cnt
);

  import rmt_pkg::lowest_set_bit;

  logic [PHV_LEN-1:0]         data_q, data_d;
  logic [C_NUM_QUEUES-1:0]    pending_q, pending_d;
  logic [CNT_W-1:0]           drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]           fwd_cnt_q, fwd_cnt_d;

  logic [C_NUM_QUEUES-1:0]    fire, nxt, dest_raw, dest;
  logic [rmt_pkg::MAX_QUEUES-1:0] dest_lsb;
  logic                       accept;

  assign dest_raw = phv_in[QUEUE_BIT_OFF +: C_NUM_QUEUES];
  assign dest_lsb = lowest_set_bit(rmt_pkg::MAX_QUEUES'(dest_raw));
  assign dest     = MCAST_EN ? dest_raw : dest_lsb[C_NUM_QUEUES-1:0];

  assign fire         = pending_q & phv_out_ready;
  assign nxt          = pending_q & ~fire;
  // Ready looks through this cycle's handshakes so a draining slot can refill with no bubble.
  assign phv_in_ready = (nxt == '0);
  assign accept       = phv_in_valid & phv_in_ready;

  always_comb begin
    data_d     = data_q;
    pending_d  = nxt;
    drop_cnt_d = drop_cnt_q;
    fwd_cnt_d  = fwd_cnt_q;
    if (accept) begin
      if (dest != '0) begin
        data_d    = phv_in;
        pending_d = dest;
      end else begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end
    if ((pending_q != '0) && (nxt == '0)) begin
      fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      data_q     <= '0;
      pending_q  <= '0;
      drop_cnt_q <= '0;
      fwd_cnt_q  <= '0;
    end else begin
      data_q     <= data_d;
      pending_q  <= pending_d;
      drop_cnt_q <= drop_cnt_d;
      fwd_cnt_q  <= fwd_cnt_d;
    end
  end

  for (genvar i = 0; i < C_NUM_QUEUES; i++) begin : g_out
    assign phv_out[i*PHV_LEN +: PHV_LEN] = data_q;
  end

  assign phv_out_valid = pending_q;
  assign drop_cnt      = drop_cnt_q;
  assign fwd_cnt       = fwd_cnt_q;

endmodule

// File: tb/tb_phv_queue_dispatcher.sv
// Self-checking bench: multicast and lowest-bit-only dispatchers against a per-queue
// scoreboard model, directed scenarios followed by randomized traffic.
module tb_phv_queue_dispatcher;

  localparam int unsigned PHV_LEN = 1152;
  localparam int unsigned NQ      = 4;
  localparam int unsigned QOFF    = 141;

  logic                    axis_clk;
  logic                    aresetn;
  logic [PHV_LEN-1:0]      phv_in;
  logic                    phv_in_valid;
  logic [NQ-1:0]           phv_out_ready;
  logic                    in_ready  [2];
  logic [NQ*PHV_LEN-1:0]   phv_out_w [2];
  logic [NQ-1:0]           out_valid [2];
  logic [31:0]             drop_cnt  [2];
  logic [31:0]             fwd_cnt   [2];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Scoreboard: PHVs still owed to each queue, plus expected counters.
  logic [PHV_LEN-1:0] exp_q [2][NQ][$];
  logic [31:0]        mdl_drop [2];
  logic [31:0]        mdl_fwd  [2];
  int unsigned        vcnt [2][NQ];
  int unsigned        anyv [2];
  int unsigned        inrdy_low [2];

  phv_queue_dispatcher #(
    .PHV_LEN(PHV_LEN), .C_NUM_QUEUES(NQ), .QUEUE_BIT_OFF(QOFF), .MCAST_EN(1'b1), .CNT_W(32)
  ) u_dut_mc (
    .axis_clk(axis_clk), .aresetn(aresetn), .phv_in(phv_in), .phv_in_valid(phv_in_valid),
    .phv_in_ready(in_ready[0]), .phv_out(phv_out_w[0]), .phv_out_valid(out_valid[0]),
    .phv_out_ready(phv_out_ready), .drop_cnt(drop_cnt[0]), .fwd_cnt(fwd_cnt[0])
  );

  phv_queue_dispatcher #(
    .PHV_LEN(PHV_LEN), .C_NUM_QUEUES(NQ), .QUEUE_BIT_OFF(QOFF), .MCAST_EN(1'b0), .CNT_W(32)
  ) u_dut_uc (
    .axis_clk(axis_clk), .aresetn(aresetn), .phv_in(phv_in), .phv_in_valid(phv_in_valid),
    .phv_in_ready(in_ready[1]), .phv_out(phv_out_w[1]), .phv_out_valid(out_valid[1]),
    .phv_out_ready(phv_out_ready), .drop_cnt(drop_cnt[1]), .fwd_cnt(fwd_cnt[1])
  );

  initial begin
    axis_clk = 1'b0;
    forever #5 axis_clk = ~axis_clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] fold(input logic [PHV_LEN-1:0] v);
    logic [63:0] r = '0;
    for (int i = 0; i < PHV_LEN / 64; i++) r ^= v[i*64 +: 64];
    return r;
  endfunction

  function automatic logic [PHV_LEN-1:0] rand_phv();
    logic [PHV_LEN-1:0] r;
    for (int i = 0; i < PHV_LEN / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called once per falling edge: checks outputs, then advances the model past the next rising edge.
  task automatic monitor();
    for (int k = 0; k < 2; k++) begin
      if (!aresetn) begin
        check($sformatf("rst_valid%0d", k), 64'(out_valid[k]), 64'd0);
        check($sformatf("rst_fwd%0d", k), 64'(fwd_cnt[k]), 64'd0);
        check($sformatf("rst_drop%0d", k), 64'(drop_cnt[k]), 64'd0);
        for (int i = 0; i < NQ; i++) exp_q[k][i].delete();
        mdl_drop[k] = '0;
        mdl_fwd[k]  = '0;
      end else begin
        logic [NQ-1:0] exp_v;
        logic          exp_rdy;
        logic          busy;
        logic [NQ-1:0] d;
        exp_v   = '0;
        exp_rdy = 1'b1;
        check($sformatf("fwd_cnt%0d", k), 64'(fwd_cnt[k]), 64'(mdl_fwd[k]));
        check($sformatf("drop_cnt%0d", k), 64'(drop_cnt[k]), 64'(mdl_drop[k]));
        for (int i = 0; i < NQ; i++) begin
          if (exp_q[k][i].size() != 0) begin
            exp_v[i] = 1'b1;
            if (!phv_out_ready[i]) exp_rdy = 1'b0;
          end
        end
        check($sformatf("valid%0d", k), 64'(out_valid[k]), 64'(exp_v));
        check($sformatf("in_ready%0d", k), 64'(in_ready[k]), 64'(exp_rdy));
        for (int i = 0; i < NQ; i++) begin
          if (out_valid[k][i] && exp_q[k][i].size() != 0)
            check($sformatf("data%0d_q%0d", k, i), fold(phv_out_w[k][i*PHV_LEN +: PHV_LEN]),
                  fold(exp_q[k][i][0]));
          if (out_valid[k][i]) vcnt[k][i]++;
        end
        if (out_valid[k] != '0) anyv[k]++;
        if (!in_ready[k]) inrdy_low[k]++;
        busy = (exp_v != '0);
        for (int i = 0; i < NQ; i++)
          if (exp_v[i] && phv_out_ready[i]) void'(exp_q[k][i].pop_front());
        if (busy) begin
          logic done = 1'b1;
          for (int i = 0; i < NQ; i++) if (exp_q[k][i].size() != 0) done = 1'b0;
          if (done) mdl_fwd[k]++;
        end
        if (phv_in_valid && exp_rdy) begin
          d = phv_in[QOFF +: NQ];
          if (k == 1) begin
            logic [NQ-1:0] lo = '0;
            for (int i = NQ - 1; i >= 0; i--) if (d[i]) lo = NQ'(1) << i;
            d = lo;
          end
          if (d == '0) mdl_drop[k]++;
          else for (int i = 0; i < NQ; i++) if (d[i]) exp_q[k][i].push_back(phv_in);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic set_in(input logic [NQ-1:0] dest);
    logic [PHV_LEN-1:0] p;
    p = rand_phv();
    p[QOFF +: NQ] = dest;
    phv_in = p;
  endtask

  initial begin
    int unsigned s0, s1, s2, s3;
    aresetn       = 1'b1;
    phv_in        = '0;
    phv_in_valid  = 1'b0;
    phv_out_ready = '0;
    for (int k = 0; k < 2; k++) begin
      mdl_drop[k] = '0; mdl_fwd[k] = '0; anyv[k] = 0; inrdy_low[k] = 0;
      for (int i = 0; i < NQ; i++) vcnt[k][i] = 0;
    end
    fork
      forever begin
        @(negedge axis_clk);
        monitor();
      end
    join_none
    #1 aresetn = 1'b0;
    repeat (3) @(posedge axis_clk);
    #3 aresetn = 1'b1;
    step();

    // Unicast
    s0 = vcnt[0][2];
    set_in(4'b0100); phv_in_valid = 1'b1; phv_out_ready = 4'b1111;
    step(); phv_in_valid = 1'b0;
    step(); step();
    check("uc_fwd", 64'(fwd_cnt[0]), 64'd1);
    check("uc_beats", 64'(vcnt[0][2] - s0), 64'd1);

    // Multicast with queue 3 stalled for 5 cycles
    s0 = vcnt[0][0]; s1 = vcnt[0][3]; s2 = inrdy_low[0]; s3 = fwd_cnt[0];
    set_in(4'b1011); phv_in_valid = 1'b1; phv_out_ready = 4'b1111;
    step(); phv_in_valid = 1'b0; phv_out_ready = 4'b0111;
    repeat (5) step();
    phv_out_ready = 4'b1111;
    step(); step(); step();
    check("mc_q0_beats", 64'(vcnt[0][0] - s0), 64'd1);
    check("mc_q3_cycles", 64'(vcnt[0][3] - s1), 64'd6);
    check("mc_inrdy_low", 64'(inrdy_low[0] - s2), 64'd5);
    check("mc_fwd", 64'(fwd_cnt[0] - s3), 64'd1);

    // Drop
    s0 = drop_cnt[0]; s1 = anyv[0];
    set_in(4'b0000); phv_in_valid = 1'b1;
    step(); phv_in_valid = 1'b0;
    step();
    check("drop_cnt", 64'(drop_cnt[0] - s0), 64'd1);
    check("drop_noval", 64'(anyv[0] - s1), 64'd0);
    check("drop_inrdy", 64'(in_ready[0]), 64'd1);

    // Back-to-back throughput
    s0 = anyv[0]; s1 = fwd_cnt[0];
    for (int j = 0; j < 8; j++) begin
      set_in(NQ'(1) << (j % 4)); phv_in_valid = 1'b1;
      step();
    end
    phv_in_valid = 1'b0;
    step();
    check("tp_beats", 64'(anyv[0] - s0), 64'd8);
    check("tp_fwd", 64'(fwd_cnt[0] - s1), 64'd8);

    // Lowest-bit-only build
    s0 = vcnt[1][2]; s1 = vcnt[1][3]; s2 = fwd_cnt[1];
    set_in(4'b1100); phv_in_valid = 1'b1;
    step(); phv_in_valid = 1'b0;
    step(); step();
    check("lsb_q2", 64'(vcnt[1][2] - s0), 64'd1);
    check("lsb_q3", 64'(vcnt[1][3] - s1), 64'd0);
    check("lsb_fwd", 64'(fwd_cnt[1] - s2), 64'd1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      set_in(($urandom_range(0, 4) == 0) ? NQ'(0) : NQ'($urandom));
      phv_in_valid = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NQ; i++) phv_out_ready[i] = ($urandom_range(0, 9) < 7);
      step();
    end
    phv_in_valid = 1'b0; phv_out_ready = 4'b1111;
    repeat (3) step();

    // Reset in the middle of a fully stalled multicast
    set_in(4'b1111); phv_in_valid = 1'b1; phv_out_ready = 4'b0000;
    step(); phv_in_valid = 1'b0;
    step();
    check("pre_rst_valid", 64'(out_valid[0]), 64'hf);
    #2 aresetn = 1'b0;
    #1;
    check("rst_async_v0", 64'(out_valid[0]), 64'd0);
    check("rst_async_v1", 64'(out_valid[1]), 64'd0);
    @(posedge axis_clk);
    @(posedge axis_clk);
    #3 aresetn = 1'b1;
    step();
    check("post_rst_fwd", 64'(fwd_cnt[0]), 64'd0);
    check("post_rst_drop", 64'(drop_cnt[0]), 64'd0);
    check("post_rst_rdy0", 64'(in_ready[0]), 64'd1);
    check("post_rst_rdy1", 64'(in_ready[1]), 64'd1);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
